// File: rtl/ex_operand_fwd_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the pipelined MIPS core EX-stage operand logic.
//   Opcode constants : ALUop, Jop, JALop, ADD_IMM, LW, SW
//   fwd_src_e        : where an operand came from (regfile/MEM/EX/immediate)
//   fwd_state_e      : load-use interlock state (RUN/STALL)
//   op_reads_rt()    : true for opcodes whose rt field names a real source
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] ALUop   = 6'd0;
  localparam logic [5:0] Jop     = 6'd2;
  localparam logic [5:0] JALop   = 6'd3;
  localparam logic [5:0] ADD_IMM = 6'd8;
  localparam logic [5:0] LW      = 6'd35;
  localparam logic [5:0] SW      = 6'd43;

  // Encoding is visible on the ex_fwd_a/ex_fwd_b ports, so values are fixed.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_EX  = 2'd2,
    FWD_IMM = 2'd3
  } fwd_src_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fwd_state_e;

  // Only R-type ALU ops and stores consume rt as a register operand; for
  // LW/ADD_IMM rt is a destination, so it must not trigger a load-use stall.
  function automatic logic op_reads_rt(input logic [5:0] op);
    return (op == ALUop) || (op == SW);
  endfunction

endpackage

// File: rtl/ex_operand_fwd_if.sv
// ---------------------------------------------------------------------------
// ex_operand_fwd_if
// Bundles the ID-stage operands, the EX/MEM forwarding sources and the
// registered EX-stage operand outputs of ex_operand_fwd.
//   master : pipeline side, drives id_*, ex_* sources, mem_*, flush
//   slave  : the operand unit, drives stall and the registered ex_* outputs
// ---------------------------------------------------------------------------
interface ex_operand_fwd_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();

  // ID stage
  logic              id_valid;
  logic [5:0]        id_op;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;
  logic [25:0]       id_imm;

  // EX stage forwarding source
  logic              ex_regwrite;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic [DATA_W-1:0] ex_result;

  // MEM stage forwarding source
  logic              mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_value;

  logic              flush;

  // Outputs of the operand unit
  logic              stall;
  logic              ex_valid;
  logic [5:0]        ex_op;
  logic [DATA_W-1:0] ex_opa;
  logic [DATA_W-1:0] ex_opb;
  logic [DATA_W-1:0] ex_store;
  logic [1:0]        ex_fwd_a;
  logic [1:0]        ex_fwd_b;

  modport master (
    output id_valid, id_op, id_rs, id_rt, id_a, id_b, id_imm,
    output ex_regwrite, ex_rd, ex_is_load, ex_result,
    output mem_regwrite, mem_rd, mem_value, flush,
    input  stall, ex_valid, ex_op, ex_opa, ex_opb, ex_store, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_a, id_b, id_imm,
    input  ex_regwrite, ex_rd, ex_is_load, ex_result,
    input  mem_regwrite, mem_rd, mem_value, flush,
    output stall, ex_valid, ex_op, ex_opa, ex_opb, ex_store, ex_fwd_a, ex_fwd_b
  );

endinterface

// File: rtl/ex_operand_fwd_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Combinational forwarding for one source register.
//   i_reg          : source register number being read
//   i_rf_val       : register-file read value for i_reg
//   i_ex_*         : EX-stage destination info and ALU result
//   i_mem_*        : MEM-stage destination info and write-back value
//   o_val / o_src  : selected value and where it came from
// ---------------------------------------------------------------------------
module fwd_select
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_reg,
  input  logic [DATA_W-1:0] i_rf_val,
  input  logic              i_ex_regwrite,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_is_load,
  input  logic [DATA_W-1:0] i_ex_result,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_value,
  output logic [DATA_W-1:0] o_val,
  output fwd_src_e          o_src
);

  // $zero is hard-wired, so it is never forwarded. The younger EX result
  // wins over MEM; a load in EX has no data yet and is handled by the
  // interlock instead of being forwarded.
  always_comb begin
    o_val = i_rf_val;
    o_src = FWD_RF;
    if (i_reg != '0) begin
      if (i_ex_regwrite && (i_ex_rd == i_reg) && !i_ex_is_load) begin
        o_val = i_ex_result;
        o_src = FWD_EX;
      end else if (i_mem_regwrite && (i_mem_rd == i_reg)) begin
        o_val = i_mem_value;
        o_src = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/ex_operand_fwd.sv
// ---------------------------------------------------------------------------
// ex_operand_fwd
// Registered EX-stage operand selection with EX/MEM forwarding, immediate
// and jump-target operand modes, and a load-use interlock.
//   clock    : pipeline clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : ex_operand_fwd_if.slave (ID operands, forwarding sources,
//              flush in; stall and registered ex_* operands out)
// Parameters: DATA_W (>= 28), REG_AW, LOAD_LAT (1..3 bubble cycles).
// ---------------------------------------------------------------------------
module ex_operand_fwd
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input logic              clock,
  input logic              reset_n,
  ex_operand_fwd_if.slave  bus
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  logic [DATA_W-1:0] w_rs_val;
  fwd_src_e          w_rs_src;
  logic [DATA_W-1:0] w_rt_val;
  fwd_src_e          w_rt_src;

  logic [27:0]       w_jump_tgt;
  logic [DATA_W-1:0] w_jump_ext;
  logic [DATA_W-1:0] w_imm_sext;

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  fwd_src_e          w_fa;
  fwd_src_e          w_fb;

  logic              w_hazard;
  logic              w_stall;
  logic              w_capture;

  fwd_state_e        r_state;
  fwd_state_e        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;

  logic              r_valid;
  logic [5:0]        r_op;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_store;
  fwd_src_e          r_fa;
  fwd_src_e          r_fb;

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_reg          (bus.id_rs),
    .i_rf_val       (bus.id_a),
    .i_ex_regwrite  (bus.ex_regwrite),
    .i_ex_rd        (bus.ex_rd),
    .i_ex_is_load   (bus.ex_is_load),
    .i_ex_result    (bus.ex_result),
    .i_mem_regwrite (bus.mem_regwrite),
    .i_mem_rd       (bus.mem_rd),
    .i_mem_value    (bus.mem_value),
    .o_val          (w_rs_val),
    .o_src          (w_rs_src)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_reg          (bus.id_rt),
    .i_rf_val       (bus.id_b),
    .i_ex_regwrite  (bus.ex_regwrite),
    .i_ex_rd        (bus.ex_rd),
    .i_ex_is_load   (bus.ex_is_load),
    .i_ex_result    (bus.ex_result),
    .i_mem_regwrite (bus.mem_regwrite),
    .i_mem_rd       (bus.mem_rd),
    .i_mem_value    (bus.mem_value),
    .o_val          (w_rt_val),
    .o_src          (w_rt_src)
  );

  // Jump target is the word-aligned 26-bit index, zero-extended; the
  // I-type immediate is sign-extended from bit 15.
  assign w_jump_tgt = {bus.id_imm, 2'b00};
  assign w_jump_ext = DATA_W'(w_jump_tgt);
  assign w_imm_sext = DATA_W'($signed(bus.id_imm[15:0]));

  // Operand selection by opcode. Unknown opcodes still forward rs on A so
  // a later decoder extension sees sensible data, and tie B to zero.
  always_comb begin
    w_opa = w_rs_val;
    w_fa  = w_rs_src;
    w_opb = '0;
    w_fb  = FWD_IMM;
    case (bus.id_op)
      ALUop: begin
        w_opb = w_rt_val;
        w_fb  = w_rt_src;
      end
      LW, SW, ADD_IMM: begin
        w_opb = w_imm_sext;
      end
      Jop, JALop: begin
        w_opa = w_jump_ext;
        w_fa  = FWD_IMM;
      end
      default: begin
        w_opb = '0;
      end
    endcase
  end

  // A load sitting in EX cannot supply its data until MEM, so a dependent
  // ID instruction must wait. r_valid is checked because a bubble left in
  // EX by a previous stall still shows the stale load on the EX inputs.
  assign w_hazard = bus.id_valid && r_valid && bus.ex_is_load &&
                    (bus.ex_rd != '0) &&
                    ((bus.ex_rd == bus.id_rs) ||
                     ((bus.ex_rd == bus.id_rt) && op_reads_rt(bus.id_op)));

  // Interlock state and bubble counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. The counter is loaded with LOAD_LAT-1 on entry so
  // that the hazard cycle plus the STALL cycles total LOAD_LAT bubbles.
  // A flush squashes the waiting instruction, so the interlock is moot.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (bus.flush) begin
      w_state_next = RUN;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            w_cnt_next   = CNT_W'(LOAD_LAT - 1);
            w_state_next = (LOAD_LAT > 1) ? STALL : RUN;
          end
        end
        STALL: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_next   = '0;
            w_state_next = RUN;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Output logic: stall holds IF/ID; an instruction is captured only when
  // nothing is holding or squashing it.
  always_comb begin
    w_stall   = 1'b0;
    w_capture = 1'b0;
    if (!bus.flush) begin
      w_stall   = (r_state == STALL) || w_hazard;
      w_capture = !w_stall && bus.id_valid;
    end
  end

  // EX-stage operand registers. On bubbles only the valid bit drops; the
  // operand values are left alone to avoid needless toggling downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_store <= '0;
      r_fa    <= FWD_RF;
      r_fb    <= FWD_RF;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_op    <= bus.id_op;
        r_opa   <= w_opa;
        r_opb   <= w_opb;
        r_store <= w_rt_val;
        r_fa    <= w_fa;
        r_fb    <= w_fb;
      end
    end
  end

  assign bus.stall    = w_stall;
  assign bus.ex_valid = r_valid;
  assign bus.ex_op    = r_op;
  assign bus.ex_opa   = r_opa;
  assign bus.ex_opb   = r_opb;
  assign bus.ex_store = r_store;
  assign bus.ex_fwd_a = r_fa;
  assign bus.ex_fwd_b = r_fb;

endmodule

// File: tb/tb_ex_operand_fwd.sv
// Testbench for ex_operand_fwd: one instance with LOAD_LAT=1 (dut1) and
// one with LOAD_LAT=3 (dut3), both driven by the same stimulus signals.
module tb_ex_operand_fwd;
  import mips_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_a, id_b;
  logic [25:0] id_imm;
  logic        ex_regwrite;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [31:0] ex_result;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_value;
  logic        flush;

  int total = 0;
  int bad   = 0;

  ex_operand_fwd_if #(.DATA_W(32), .REG_AW(5)) bus1 ();
  ex_operand_fwd_if #(.DATA_W(32), .REG_AW(5)) bus3 ();

  assign bus1.id_valid = id_valid;         assign bus3.id_valid = id_valid;
  assign bus1.id_op = id_op;               assign bus3.id_op = id_op;
  assign bus1.id_rs = id_rs;               assign bus3.id_rs = id_rs;
  assign bus1.id_rt = id_rt;               assign bus3.id_rt = id_rt;
  assign bus1.id_a = id_a;                 assign bus3.id_a = id_a;
  assign bus1.id_b = id_b;                 assign bus3.id_b = id_b;
  assign bus1.id_imm = id_imm;             assign bus3.id_imm = id_imm;
  assign bus1.ex_regwrite = ex_regwrite;   assign bus3.ex_regwrite = ex_regwrite;
  assign bus1.ex_rd = ex_rd;               assign bus3.ex_rd = ex_rd;
  assign bus1.ex_is_load = ex_is_load;     assign bus3.ex_is_load = ex_is_load;
  assign bus1.ex_result = ex_result;       assign bus3.ex_result = ex_result;
  assign bus1.mem_regwrite = mem_regwrite; assign bus3.mem_regwrite = mem_regwrite;
  assign bus1.mem_rd = mem_rd;             assign bus3.mem_rd = mem_rd;
  assign bus1.mem_value = mem_value;       assign bus3.mem_value = mem_value;
  assign bus1.flush = flush;               assign bus3.flush = flush;

  ex_operand_fwd #(.DATA_W(32), .REG_AW(5), .LOAD_LAT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1)
  );

  ex_operand_fwd #(.DATA_W(32), .REG_AW(5), .LOAD_LAT(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus(bus3)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] a, b;
    logic [25:0] imm;
    logic        exrw;
    logic [4:0]  exrd;
    logic        exload;
    logic [31:0] exres;
    logic        memrw;
    logic [4:0]  memrd;
    logic [31:0] memval;
    logic        fl;
    logic        evalid;
    logic [5:0]  eop;
    logic [31:0] eopa, eopb, estore;
    logic [1:0]  efa, efb;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(
    input logic valid, input logic [5:0] op, input logic [4:0] rs, rt,
    input logic [31:0] a, b, input logic [25:0] imm,
    input logic exrw, input logic [4:0] exrd, input logic exload, input logic [31:0] exres,
    input logic memrw, input logic [4:0] memrd, input logic [31:0] memval, input logic fl,
    input logic evalid, input logic [5:0] eop, input logic [31:0] eopa, eopb, estore,
    input logic [1:0] efa, efb);
    vec_t v;
    v.valid = valid; v.op = op; v.rs = rs; v.rt = rt; v.a = a; v.b = b; v.imm = imm;
    v.exrw = exrw; v.exrd = exrd; v.exload = exload; v.exres = exres;
    v.memrw = memrw; v.memrd = memrd; v.memval = memval; v.fl = fl;
    v.evalid = evalid; v.eop = eop; v.eopa = eopa; v.eopb = eopb; v.estore = estore;
    v.efa = efa; v.efb = efb;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_valid = v.valid; id_op = v.op; id_rs = v.rs; id_rt = v.rt;
    id_a = v.a; id_b = v.b; id_imm = v.imm;
    ex_regwrite = v.exrw; ex_rd = v.exrd; ex_is_load = v.exload; ex_result = v.exres;
    mem_regwrite = v.memrw; mem_rd = v.memrd; mem_value = v.memval; flush = v.fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n = 1'b0;
    setIdle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Put one valid SW into dut3's EX register so the interlock can fire.
  task automatic primeDut3();
    applyStimulus(mk(1, SW, 1, 2, 32'h11, 32'h22, 26'h4, 0, 0, 0, 0,
                     1, 2, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock); @(negedge clock);
    checkOutput("prime_valid", 32'(bus3.ex_valid), 32'd1);
  endtask

  // Load in EX writing r7, ALU in ID reading r7.
  task automatic setHazard();
    applyStimulus(mk(1, ALUop, 7, 2, 32'h71, 32'h22, 0, 1, 7, 1, 32'hEEE,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, ALUop, 3, 4, 32'h1000, 32'h2000, 0, 1, 3, 0, 32'h11, 1, 4, 32'h22, 0,
                  1, ALUop, 32'h11, 32'h22, 32'h22, 2, 1);
    vecs[1]  = mk(1, ALUop, 5, 6, 32'h50, 32'h60, 0, 1, 5, 0, 32'hAA, 1, 5, 32'hBB, 0,
                  1, ALUop, 32'hAA, 32'h60, 32'h60, 2, 0);
    vecs[2]  = mk(1, ALUop, 0, 6, 32'h123, 32'h66, 0, 1, 0, 0, 32'hAA, 1, 0, 32'hBB, 0,
                  1, ALUop, 32'h123, 32'h66, 32'h66, 0, 0);
    vecs[3]  = mk(1, JALop, 0, 1, 32'h0, 32'h77, 26'h40, 0, 0, 0, 0, 0, 0, 0, 0,
                  1, JALop, 32'h100, 32'h0, 32'h77, 3, 3);
    vecs[4]  = mk(1, ADD_IMM, 2, 9, 32'h10, 32'h99, 26'h0FFFE, 0, 0, 0, 0, 0, 0, 0, 0,
                  1, ADD_IMM, 32'h10, 32'hFFFFFFFE, 32'h99, 0, 3);
    vecs[5]  = mk(1, SW, 1, 2, 32'h100, 32'h200, 26'h4, 0, 0, 0, 0, 1, 2, 32'h333, 0,
                  1, SW, 32'h100, 32'h4, 32'h333, 0, 3);
    vecs[6]  = mk(1, LW, 9, 8, 32'h900, 32'h800, 26'h8000, 1, 8, 1, 32'hEEE, 1, 8, 32'h444, 0,
                  1, LW, 32'h900, 32'hFFFF8000, 32'h444, 0, 3);
    vecs[7]  = mk(0, ALUop, 1, 1, 32'h5, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                  0, LW, 32'h900, 32'hFFFF8000, 32'h444, 0, 3);
    vecs[8]  = mk(1, 6'h3F, 3, 0, 32'h5, 32'h9, 0, 1, 3, 0, 32'hC, 1, 0, 32'hFF, 0,
                  1, 6'h3F, 32'hC, 32'h0, 32'h9, 2, 3);
    vecs[9]  = mk(1, Jop, 4, 0, 32'h1, 32'h0, 26'h3FFFFFF, 1, 4, 0, 32'h55, 0, 0, 0, 0,
                  1, Jop, 32'h0FFFFFFC, 32'h0, 32'h0, 3, 3);
    vecs[10] = mk(1, ALUop, 1, 1, 32'h7, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                  0, Jop, 32'h0FFFFFFC, 32'h0, 32'h0, 3, 3);
    vecs[11] = mk(1, ALUop, 4, 5, 32'h44, 32'h55, 0, 0, 4, 0, 32'hDEAD, 0, 5, 32'hBEEF, 0,
                  1, ALUop, 32'h44, 32'h55, 32'h55, 0, 0);

    reset_n = 1'b0;
    setIdle();
    #12;
    checkOutput("rst_stall",    32'(bus1.stall), 32'd0);
    checkOutput("rst_valid",    32'(bus1.ex_valid), 32'd0);
    checkOutput("rst_opa",      bus1.ex_opa, 32'd0);
    checkOutput("rst_fwd_a",    32'(bus1.ex_fwd_a), 32'd0);
    checkOutput("rst_valid3",   32'(bus3.ex_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven single-cycle checks on dut1
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_stall", i), 32'(bus1.stall), 32'd0);
      @(posedge clock); @(negedge clock);
      checkOutput($sformatf("v%0d_valid", i), 32'(bus1.ex_valid), 32'(vecs[i].evalid));
      checkOutput($sformatf("v%0d_op", i),    32'(bus1.ex_op), 32'(vecs[i].eop));
      checkOutput($sformatf("v%0d_opa", i),   bus1.ex_opa, vecs[i].eopa);
      checkOutput($sformatf("v%0d_opb", i),   bus1.ex_opb, vecs[i].eopb);
      checkOutput($sformatf("v%0d_store", i), bus1.ex_store, vecs[i].estore);
      checkOutput($sformatf("v%0d_fwd_a", i), 32'(bus1.ex_fwd_a), 32'(vecs[i].efa));
      checkOutput($sformatf("v%0d_fwd_b", i), 32'(bus1.ex_fwd_b), 32'(vecs[i].efb));
    end

    // Load-use with LOAD_LAT=1: one bubble, then MEM forwarding
    setHazard();
    #1;
    checkOutput("lu1_stall", 32'(bus1.stall), 32'd1);
    @(posedge clock); @(negedge clock);
    checkOutput("lu1_bubble", 32'(bus1.ex_valid), 32'd0);
    ex_regwrite = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    mem_regwrite = 1'b1; mem_rd = 5'd7; mem_value = 32'h5A5A;
    #1;
    checkOutput("lu1_stall_clr", 32'(bus1.stall), 32'd0);
    @(posedge clock); @(negedge clock);
    checkOutput("lu1_valid", 32'(bus1.ex_valid), 32'd1);
    checkOutput("lu1_opa",   bus1.ex_opa, 32'h5A5A);
    checkOutput("lu1_fwd_a", 32'(bus1.ex_fwd_a), 32'd1);

    // Load-use with LOAD_LAT=3: stall exactly three cycles
    doReset();
    primeDut3();
    setHazard();
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("lu3_stall_c%0d", i), 32'(bus3.stall), (i < 3) ? 32'd1 : 32'd0);
      @(posedge clock); @(negedge clock);
      checkOutput($sformatf("lu3_valid_c%0d", i), 32'(bus3.ex_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("lu3_opa",   bus3.ex_opa, 32'h71);
    checkOutput("lu3_fwd_a", 32'(bus3.ex_fwd_a), 32'd0);

    // Flush in the second stall cycle returns to RUN
    doReset();
    primeDut3();
    setHazard();
    #1;
    checkOutput("fl_stall_c0", 32'(bus3.stall), 32'd1);
    @(posedge clock); @(negedge clock);
    flush = 1'b1;
    #1;
    checkOutput("fl_stall_c1", 32'(bus3.stall), 32'd0);
    @(posedge clock); @(negedge clock);
    checkOutput("fl_valid", 32'(bus3.ex_valid), 32'd0);
    flush = 1'b0;
    #1;
    checkOutput("fl_run_stall", 32'(bus3.stall), 32'd0);
    @(posedge clock); @(negedge clock);
    checkOutput("fl_capture", 32'(bus3.ex_valid), 32'd1);
    checkOutput("fl_opa",     bus3.ex_opa, 32'h71);

    // Asynchronous reset in the middle of a stall
    doReset();
    primeDut3();
    setHazard();
    @(posedge clock); @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_stall", 32'(bus3.stall), 32'd0);
    checkOutput("ar_valid", 32'(bus3.ex_valid), 32'd0);
    checkOutput("ar_op",    32'(bus3.ex_op), 32'd0);
    checkOutput("ar_opa",   bus3.ex_opa, 32'd0);
    checkOutput("ar_opb",   bus3.ex_opb, 32'd0);
    checkOutput("ar_store", bus3.ex_store, 32'd0);
    checkOutput("ar_fwd_b", 32'(bus3.ex_fwd_b), 32'd0);
    applyStimulus(mk(1, ALUop, 6, 7, 32'h1234, 32'h5678, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    checkOutput("ar_post_valid", 32'(bus3.ex_valid), 32'd1);
    checkOutput("ar_post_opa",   bus3.ex_opa, 32'h1234);
    checkOutput("ar_post_opb",   bus3.ex_opb, 32'h5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
